// File: rtl/res_com8.sv
// res_com8: bit-serial subtractor that recovers operand A = C - B from the
// (W+1)-bit sum C produced by Sum_com8 and the known operand B.
// One difference bit is produced per clock, LSB first. The result is flagged
// invalid when C < B (final borrow) or when the difference needs bit W.
// Handshake: start is accepted in IDLE only; busy marks the W+1 shift steps;
// done pulses for one cycle when A/err are updated.

module res_com8 #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W:0]   C,
  input  logic [W-1:0] B,
  output logic [W-1:0] A,
  output logic         err,
  output logic         busy,
  output logic         done
);

  // Step counter must hold values 0..W inclusive.
  localparam int unsigned CW = $clog2(W + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(W);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // One-bit full subtractor: returns {borrow_out, difference}.
  function automatic logic [1:0] full_sub(
    input logic x,
    input logic y,
    input logic bin
  );
    logic d;
    logic bout;
    d    = x ^ y ^ bin;
    bout = (~x & y) | (~x & bin) | (y & bin);
    return {bout, d};
  endfunction

  state_t         state_q, state_d;
  logic [W:0]     cr_q, cr_d;     // minuend shift register
  logic [W:0]     br_q, br_d;     // zero-extended subtrahend shift register
  logic           bor_q, bor_d;   // running borrow
  logic [CW-1:0]  cnt_q, cnt_d;   // completed-step counter
  logic [W:0]     res_q, res_d;   // difference assembled MSB-side first
  logic [W-1:0]   a_q, a_d;
  logic           err_q, err_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic [1:0]     fs_s;           // current step {borrow_out, diff_bit}
  logic [W:0]     res_next_s;     // difference after the current step

  // Arithmetic for the current step, computed from the LSBs of the shifters.
  always_comb begin
    fs_s       = full_sub(cr_q[0], br_q[0], bor_q);
    res_next_s = {fs_s[0], res_q[W:1]};
  end

  // Next-state and datapath update; outputs flags follow the next state so
  // busy/done leave registers aligned with the state they describe.
  always_comb begin
    state_d = state_q;
    cr_d    = cr_q;
    br_d    = br_q;
    bor_d   = bor_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    a_d     = a_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SHIFT;
          cr_d    = C;
          br_d    = {1'b0, B};
          bor_d   = 1'b0;
          cnt_d   = '0;
          res_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        bor_d = fs_s[1];
        res_d = res_next_s;
        cr_d  = {1'b0, cr_q[W:1]};
        br_d  = {1'b0, br_q[W:1]};
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          // Last step: publish the low W bits; bit W or a final borrow
          // means the difference is not a valid W-bit adder operand.
          state_d = ST_DONE;
          a_d     = res_next_s[W-1:0];
          err_d   = fs_s[1] | res_next_s[W];
        end else begin
          state_d = ST_SHIFT;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_SHIFT);
    done_d = (state_d == ST_DONE);
  end

  // State, datapath and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cr_q    <= '0;
      br_q    <= '0;
      bor_q   <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      a_q     <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cr_q    <= cr_d;
      br_q    <= br_d;
      bor_q   <= bor_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      a_q     <= a_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign A    = a_q;
  assign err  = err_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_res_com8.sv
// Directed bench for res_com8: hand-computed differences, handshake timing,
// ignored starts, back-to-back throughput and mid-operation reset.

module tb_res_com8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [8:0] C;
  logic [7:0] B;
  logic [7:0] A;
  logic       err;
  logic       busy;
  logic       done;

  int vectors = 0;
  int miscompares = 0;

  res_com8 #(.W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .C     (C),
    .B     (B),
    .A     (A),
    .err   (err),
    .busy  (busy),
    .done  (done)
  );

  // 10-unit clock period.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation from IDLE and check the full handshake and result.
  task automatic run_op(input logic [8:0] c, input logic [7:0] b,
                        input logic [7:0] ea, input logic ee, input string tag);
    int nbusy;
    int ndone;
    nbusy = 0;
    ndone = 0;
    @(negedge clk);
    C = c; B = b; start = 1'b1;
    @(negedge clk);                       // cycle 1 after accept edge
    start = 1'b0; C = 9'h1AA; B = 8'h55;  // operands may change freely
    for (int i = 0; i < 9; i++) begin
      if (busy === 1'b1 && done === 1'b0) nbusy++;
      if (done === 1'b1) ndone++;
      @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, 32'(nbusy), 32'd9);
    chk({tag, "_early_done"}, 32'(ndone), 32'd0);
    chk({tag, "_done"}, {30'd0, busy, done}, 32'h1);
    chk({tag, "_A"}, 32'(A), 32'(ea));
    chk({tag, "_err"}, 32'(err), 32'(ee));
    @(negedge clk);
    chk({tag, "_idle"}, {30'd0, busy, done}, 32'h0);
    chk({tag, "_A_hold"}, 32'(A), 32'(ea));
  endtask

  initial begin
    int ndone;
    int nbusy;
    int t0, t1, t2, seen;

    rst_n = 1'b0; start = 1'b0; C = 9'h000; B = 8'h00;
    #12;
    chk("rst_A", 32'(A), 32'h00);
    chk("rst_flags", {29'd0, err, busy, done}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Main function, borrow/overflow, boundaries and round-trips.
    run_op(9'h00C, 8'h02, 8'h0A, 1'b0, "basic");
    run_op(9'h003, 8'h05, 8'hFE, 1'b1, "borrow");
    run_op(9'h113, 8'h0F, 8'h04, 1'b1, "ovf");
    run_op(9'h005, 8'h05, 8'h00, 1'b0, "equal");
    run_op(9'h1FE, 8'hFF, 8'hFF, 1'b0, "max");
    run_op(9'h000, 8'h00, 8'h00, 1'b0, "zero");
    run_op(9'h013, 8'h0F, 8'h04, 1'b0, "rt1");
    run_op(9'h006, 8'h05, 8'h01, 1'b0, "rt2");

    // Starts during SHIFT and during DONE are ignored.
    @(negedge clk);
    C = 9'h00C; B = 8'h02; start = 1'b1;
    @(negedge clk);                       // cycle 1
    start = 1'b0;
    repeat (3) @(negedge clk);            // cycle 4, in SHIFT
    C = 9'h1FF; B = 8'h00; start = 1'b1;
    @(negedge clk);                       // cycle 5
    start = 1'b0;
    repeat (5) @(negedge clk);            // cycle 10, DONE
    chk("hs_done", 32'(done), 32'h1);
    chk("hs_A", 32'(A), 32'h0A);
    chk("hs_err", 32'(err), 32'h0);
    C = 9'h003; B = 8'h05; start = 1'b1;  // pulse during DONE
    @(negedge clk);
    start = 1'b0;
    ndone = 0; nbusy = 0;
    for (int i = 0; i < 14; i++) begin
      if (done === 1'b1) ndone++;
      if (busy === 1'b1) nbusy++;
      @(negedge clk);
    end
    chk("hs_no_extra_done", 32'(ndone), 32'd0);
    chk("hs_no_restart", 32'(nbusy), 32'd0);
    chk("hs_A_keep", 32'(A), 32'h0A);

    // start held high: one completion every 11 cycles.
    C = 9'h00C; B = 8'h02; start = 1'b1;
    t0 = -1; t1 = -1; t2 = -1; seen = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done === 1'b1 && busy === 1'b1) seen = 99;
      if (done === 1'b1) begin
        if (seen == 0) t0 = i;
        else if (seen == 1) t1 = i;
        else if (seen == 2) t2 = i;
        seen++;
      end
    end
    start = 1'b0;
    chk("hold_first", 32'(t0), 32'd10);
    chk("hold_period1", 32'(t1 - t0), 32'd11);
    chk("hold_period2", 32'(t2 - t1), 32'd11);
    chk("hold_A", 32'(A), 32'h0A);
    repeat (14) @(negedge clk);
    chk("hold_idle", {30'd0, busy, done}, 32'h0);

    // Mid-operation reset: load a nonzero result first so clearing is visible.
    run_op(9'h113, 8'h0F, 8'h04, 1'b1, "pre_rst");
    @(negedge clk);
    C = 9'h00C; B = 8'h02; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);            // step 4
    chk("pre_rst_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_A", 32'(A), 32'h00);
    chk("arst_err_done", {30'd0, err, done}, 32'h0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
      if (i == 2) rst_n = 1'b1;
    end
    chk("arst_no_done", 32'(ndone), 32'd0);
    chk("arst_A_after", 32'(A), 32'h00);
    run_op(9'h00C, 8'h02, 8'h0A, 1'b0, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
